// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, BIST state encoding and the expected-pattern function.
package ram_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 32;
  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} bist_state_e;
  // Upper half is inverted so a bit stuck at either value disagrees somewhere.
  function automatic logic [DATA_W-1:0] exp_pat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] s);
    return a[DATA_W-1:0] ^ s ^ {DATA_W{a[ADDR_W-1]}};
  endfunction
endpackage

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: combinational expected word for an address and seed.
module bist_pattern_gen import ram_pkg::*; (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] pattern
);
  assign pattern = exp_pat(addr, seed);
endmodule

// File: rtl/ram32x4_bist.sv
// ram32x4_bist: write/read-back self-test sequencer for a 32x4 synchronous RAM.
module ram32x4_bist import ram_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  bist_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, raddr_q, raddr_d, ferr_q, ferr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] seed_q, seed_d, wpat, rpat, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0] err_q, err_d;
  logic vld_q, vld_d, pass_q, pass_d, mismatch;
  logic mem_en_q, mem_en_d, mem_wen_q, mem_wen_d, busy_q, busy_d, done_q, done_d;
  bist_pattern_gen u_wgen (.addr(cnt_d), .seed(seed_d), .pattern(wpat));
  bist_pattern_gen u_rgen (.addr(raddr_q), .seed(seed_q), .pattern(rpat));
  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = WRITE;
        cnt_d   = '0;
        seed_d  = seed;
        err_d   = '0;
        ferr_d  = '0;
        pass_d  = 1'b0;
      end
      WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? READ : WRITE;
      end
      READ: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? CHECK : READ;
      end
      CHECK:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    mismatch = vld_q && (mem_rdata != rpat);
    if (mismatch) begin
      err_d  = err_q + 1'b1;
      ferr_d = (err_q == '0) ? raddr_q : ferr_q;
    end
    if (state_d == DONE) pass_d = (err_d == '0);
    vld_d       = (state_q == READ);
    raddr_d     = cnt_q;
    mem_en_d    = (state_d == WRITE) || (state_d == READ);
    mem_wen_d   = (state_d == WRITE);
    mem_addr_d  = mem_en_d ? cnt_d : '0;
    mem_wdata_d = mem_wen_d ? wpat : '0;
    busy_d      = mem_en_d || (state_d == CHECK);
    done_d      = (state_d == DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seed_q      <= '0;
      err_q       <= '0;
      ferr_q      <= '0;
      pass_q      <= 1'b0;
      vld_q       <= 1'b0;
      raddr_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      pass_q      <= pass_d;
      vld_q       <= vld_d;
      raddr_q     <= raddr_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign mem_en         = mem_en_q;
  assign mem_wen        = mem_wen_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_ram32x4_bist.sv
// tb_ram32x4_bist: random seeds and injected RAM faults checked against a reference model.
module tb_ram32x4_bist;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] seed = '0, mem_wdata, mem_rdata;
  logic mem_en, mem_wen, busy, done, pass;
  logic [4:0] mem_addr, first_err_addr;
  logic [5:0] err_count;
  logic [3:0] mem [32];
  logic [3:0] cur_seed = '0;
  int vectors = 0, errors = 0, ndone = 0, wcnt = 0, rcnt = 0;
  int stuck_bit = 0, corr_addr = 0;
  logic stuck_en = 1'b0, stuck_val = 1'b0, corr_en = 1'b0;
  logic [3:0] corr_mask = 4'h1;

  ram32x4_bist dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_exp(int a, logic [3:0] s);
    return 4'((a % 16) ^ s ^ (a >= 16 ? 15 : 0));
  endfunction

  function automatic logic [3:0] fault(int a, logic [3:0] d);
    logic [3:0] r = d;
    if (stuck_en) r[stuck_bit] = stuck_val;
    if (corr_en && a == corr_addr) r ^= corr_mask;
    return r;
  endfunction

  always @(posedge clk)
    if (mem_en) begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= fault(int'(mem_addr), mem[mem_addr]);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (done) ndone++;
      if (mem_en && mem_wen) begin
        chk("waddr", mem_addr, wcnt % 32);
        chk("wdata", mem_wdata, ref_exp(wcnt % 32, cur_seed));
        wcnt++;
      end
      if (mem_en && !mem_wen) begin
        chk("raddr", mem_addr, rcnt % 32);
        rcnt++;
      end
    end

  task automatic launch(input logic [3:0] s);
    @(negedge clk);
    seed = s; start = 1'b1; cur_seed = s; wcnt = 0; rcnt = 0;
    @(negedge clk);
    start = 1'b0; seed = 4'($urandom);
  endtask

  task automatic wait_done(inout int cyc);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_check(input logic [3:0] s, input int cyc);
    int ne = 0, fe = 0;
    for (int a = 0; a < 32; a++)
      if (fault(a, ref_exp(a, s)) != ref_exp(a, s)) begin
        if (ne == 0) fe = a;
        ne++;
      end
    chk("done_cyc", cyc, 66);
    chk("done", done, 1);
    chk("err_count", err_count, ne);
    chk("first_err", first_err_addr, fe);
    chk("pass", pass, ne == 0);
    chk("busy_done", busy, 0);
    chk("nwrites", wcnt, 32);
    chk("nreads", rcnt, 32);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("hold_err", err_count, ne);
    chk("hold_pass", pass, ne == 0);
  endtask

  task automatic run_check(input logic [3:0] s);
    int cyc = 1, n0 = ndone;
    launch(s);
    chk("busy_start", busy, 1);
    wait_done(cyc);
    finish_check(s, cyc);
    chk("ndone", ndone - n0, 1);
  endtask

  initial begin
    int cyc, n0;
    repeat (3) @(negedge clk);
    chk("rst_en", mem_en, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ferr", first_err_addr, 0);
    rst = 1'b0;
    run_check(4'h0);
    run_check(4'hA);
    chk("word5", mem[5], 4'hF);
    chk("word21", mem[21], 4'h0);
    stuck_en = 1'b1; stuck_bit = 2; stuck_val = 1'b0;
    run_check(4'h0);
    chk("stuck_err", err_count, 16);
    chk("stuck_ferr", first_err_addr, 4);
    stuck_en = 1'b0; corr_en = 1'b1; corr_addr = 31; corr_mask = 4'($urandom_range(1, 15));
    run_check(4'($urandom));
    chk("last_err", err_count, 1);
    chk("last_ferr", first_err_addr, 31);
    corr_en = 1'b0;
    // Restart attempts mid-write and across DONE must not disturb the running test.
    n0 = ndone;
    launch(4'h3);
    repeat (9) @(negedge clk);
    start = 1'b1; seed = 4'hC;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    start = 1'b1; seed = 4'h5;
    cyc = 60;
    wait_done(cyc);
    chk("rp_done_cyc", cyc, 66);
    chk("rp_pass", pass, 1);
    chk("rp_err", err_count, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    chk("rp_ndone", ndone - n0, 1);
    chk("rp_busy", busy, 0);
    chk("rp_en", mem_en, 0);
    // Reset mid-read with errors already accumulated.
    stuck_en = 1'b1; stuck_bit = 0; stuck_val = 1'b0;
    n0 = ndone;
    launch(4'h0);
    repeat (39) @(negedge clk);
    chk("pre_rst_err", err_count != 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_en", mem_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_err", err_count, 0);
    chk("ar_pass", pass, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("ar_ndone", ndone - n0, 0);
    chk("ar_idle_en", mem_en, 0);
    stuck_en = 1'b0;
    run_check(4'($urandom));
    for (int i = 0; i < 8; i++) begin
      stuck_en  = 1'($urandom_range(0, 1));
      stuck_bit = $urandom_range(0, 3);
      stuck_val = 1'($urandom_range(0, 1));
      corr_en   = 1'($urandom_range(0, 1));
      corr_addr = $urandom_range(0, 31);
      corr_mask = 4'($urandom_range(1, 15));
      run_check(4'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ram32x4_bist.md
Name: ram32x4_bist

Overview:
- Initiator for the 32x4 single-port synchronous RAM interface (`en`, `wen`, `address`, `data_in`, `data_out`).
- On command, writes a seed-derived pattern to every word, reads every word back, compares it and reports the result.
- Sits beside the RAM as a built-in self-test sequencer. A top-level mux selects BIST or functional traffic onto the RAM port.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 4, RAM word width.
- DEPTH, 32, number of words tested. Must equal 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle test request. Honoured only in IDLE.
- seed  in  DATA_W  pattern seed. Latched when start is accepted.
- mem_en  out  1  RAM enable.
- mem_wen  out  1  RAM write enable (1 = write, 0 = read).
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data. Valid one cycle after a read is issued with mem_en=1 and mem_wen=0.
- busy  out  1  high from the cycle after start is accepted through CHECK.
- done  out  1  one-cycle pulse when results are final.
- pass  out  1  1 when err_count is 0. Valid from done until the next accepted start.
- err_count  out  ADDR_W+1  number of mismatching words, 0..32.
- first_err_addr  out  ADDR_W  lowest mismatching address. 0 if none.

Behaviour:
- Reset: state=IDLE. mem_en, mem_wen, mem_addr, mem_wdata, busy, done, pass, err_count and first_err_addr are all 0. The seed register is 0.
- Reset asserted in any state aborts the test on the next edge:
  - no further RAM accesses;
  - partial results are discarded;
  - no done pulse.
- Expected pattern: exp(a) = a[3:0] XOR seed_q XOR {4{a[4]}}. The upper half is inverted, so a bit stuck at either value is always exposed.
- States and transitions:
  - IDLE:
    - mem_en=0, busy=0.
    - start=1 → latch seed_q, clear err_count, first_err_addr and pass; go to WRITE with the address counter at 0.
  - WRITE:
    - mem_en=1, mem_wen=1, mem_addr=cnt, mem_wdata=exp(cnt).
    - cnt increments every cycle, 32 cycles total.
    - After cnt=31 → READ with cnt=0.
  - READ:
    - mem_en=1, mem_wen=0, mem_addr=cnt, mem_wdata=0.
    - A registered copy of the address and a valid flag track the one-cycle read latency.
    - Each cycle with the flag set compares mem_rdata against exp(previous address).
    - 32 cycles; after cnt=31 → CHECK.
  - CHECK:
    - mem_en=0.
    - Performs the final comparison, for address 31.
    - Next state DONE.
  - DONE:
    - busy=0, done=1 for exactly one cycle.
    - pass = (err_count==0).
    - Next state IDLE.
- Timing: if start is sampled at edge N:
  - WRITE occupies cycles N+1..N+32;
  - READ occupies N+33..N+64;
  - CHECK is N+65;
  - done is high in cycle N+66.
- Mismatch handling:
  - err_count increments by 1.
  - On the first mismatch only, first_err_addr captures the address.
  - err_count cannot overflow: its maximum is 32, which fits in 6 bits.
- Boundary conditions:
  - start while busy, or in DONE, is ignored.
  - start in the same cycle as rst is ignored; reset wins.
  - Results (pass, err_count, first_err_addr) hold in IDLE until the next accepted start.
  - The address counter wraps 31→0 at each phase change and never exceeds DEPTH-1.
- All outputs are registered. No combinational path from mem_rdata to any output.

Decomposition:
- Shared package `ram_pkg`:
  - ADDR_W, DATA_W and DEPTH constants;
  - the BIST state enum (IDLE, WRITE, READ, CHECK, DONE);
  - the exp() pattern function, so the bench reuses the same definition.
- One sub-module, `bist_pattern_gen`: combinational exp(addr, seed). The FSM, counter and comparator stay in the top module.

Test Plan:
- Clean RAM, seed=4'h0, start pulse → writes 0..F then F..0 (inverted upper half). done at start+66. pass=1, err_count=0, first_err_addr=0.
- Clean RAM, seed=4'hA → word 5 written 4'hF, word 21 written 4'h0. pass=1.
- RAM model with data bit 2 stuck at 0, seed=4'h0 → err_count=16, first_err_addr=4, pass=0.
- RAM model corrupting only address 31 on read → err_count=1, first_err_addr=31. This checks the final compare in CHECK.
- start re-pulsed at cycle 10 of WRITE, and start held high through DONE → only one test runs, exactly one done pulse, the first seed is retained.
- rst asserted in cycle 40 (mid-READ) → next cycle mem_en=0, busy=0, err_count=0, no done pulse. A subsequent start completes normally with pass=1.
